// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the converter sequencer and the
// double-dabble converter it drives.
//   - state_t      : sequencer state encoding
//   - DEF_BIN_W    : default binary operand width
//   - DEF_BCD_W    : default BCD result width (4 bits per digit)
//   - DEF_DIGITS   : number of BCD digits in the default result
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int DEF_BIN_W  = 8;
  localparam int DEF_BCD_W  = 12;
  localparam int DEF_DIGITS = DEF_BCD_W / 4;

  // Width of a lane index; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: bundles the requester-side and converter-side
// signals of the shared BCD converter sequencer.
//   Requester side : req, bin_in (in)  / gnt, rsp_valid, bcd_out, err, busy (out)
//   Converter side : conv_done, conv_bcd (in) / conv_init, conv_bin (out)
// Modports:
//   slave  - the sequencer's view (bcd_conv_arbiter)
//   master - the environment's view (requesters plus converter)
interface bcd_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int BIN_W = 8,
  parameter int BCD_W = 12
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*BIN_W-1:0] bin_in;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [BCD_W-1:0]       bcd_out;
  logic                   err;
  logic                   busy;
  logic                   conv_init;
  logic [BIN_W-1:0]       conv_bin;
  logic                   conv_done;
  logic [BCD_W-1:0]       conv_bcd;

  modport slave (
    input  req, bin_in, conv_done, conv_bcd,
    output gnt, rsp_valid, bcd_out, err, busy, conv_init, conv_bin
  );

  modport master (
    output req, bin_in, conv_done, conv_bcd,
    input  gnt, rsp_valid, bcd_out, err, busy, conv_init, conv_bin
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select.
//   req     (in)  : level requests, one bit per lane
//   ptr     (in)  : last served lane; search starts at ptr+1 mod N_REQ
//   win_idx (out) : index of the winning lane (0 when none)
//   any     (out) : at least one request is pending
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  assign any = |req;

  // Walk offsets from farthest (ptr itself) to nearest (ptr+1); the last
  // hit overwrites earlier ones, so the nearest requester after ptr wins.
  always_comb begin
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N_REQ])
        win_idx = IDX_W'((int'(ptr) + k) % N_REQ);
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: shares one binary-to-BCD converter among N_REQ lanes.
// A round-robin winner's operand is captured, the converter is started with
// a one-cycle init, and its result is returned to the winner with a
// one-cycle rsp_valid. A watchdog ends a conversion that never completes,
// returning zero with err.
//   clk (in) : clock, rising edge
//   rst (in) : synchronous reset, active low
//   bus      : slave modport of bcd_conv_arbiter_if
//              (req/bin_in/gnt/rsp_valid/bcd_out/err/busy,
//               conv_init/conv_bin/conv_done/conv_bcd)
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BIN_W   = DEF_BIN_W,
  parameter int BCD_W   = DEF_BCD_W,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  bcd_conv_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT);

  state_t                        state;
  logic [IDX_W-1:0]              ptr;
  logic [IDX_W-1:0]              idx;
  logic [TMR_W-1:0]              timer;
  logic [BIN_W-1:0]              conv_bin_q;
  logic [BCD_W-1:0]              bcd_q;
  logic                          err_q;

  logic [IDX_W-1:0]              win_idx;
  logic                          any;
  logic [N_REQ-1:0][BIN_W-1:0]   lane_bin;

  // Packed layout matches bin_in: lane i sits at [i*BIN_W +: BIN_W].
  assign lane_bin = bus.bin_in;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (bus.req),
    .ptr     (ptr),
    .win_idx (win_idx),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= IDX_W'(N_REQ - 1);
      idx        <= '0;
      timer      <= '0;
      conv_bin_q <= '0;
      bcd_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            idx        <= win_idx;
            conv_bin_q <= lane_bin[win_idx];
            timer      <= '0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          // done takes precedence over an expiring timer
          if (bus.conv_done) begin
            bcd_q <= bus.conv_bcd;
            err_q <= 1'b0;
            state <= RESP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            bcd_q <= '0;
            err_q <= 1'b1;
            state <= RESP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RESP: begin
          ptr   <= idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs decoded from state and registers.
  assign bus.busy      = (state != IDLE);
  assign bus.conv_init = (state == LAUNCH);
  assign bus.conv_bin  = conv_bin_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.err       = (state == RESP) && err_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign bus.gnt[i]       = (state != IDLE) && (idx == IDX_W'(i));
    assign bus.rsp_valid[i] = (state == RESP) && (idx == IDX_W'(i));
  end

`ifdef BENCH
  string state_name;
  always_comb begin
    case (state)
      IDLE:    state_name = "IDLE";
      LAUNCH:  state_name = "LAUNCH";
      WAIT:    state_name = "WAIT";
      RESP:    state_name = "RESP";
      default: state_name = "???";
    endcase
  end
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed scoreboard bench for bcd_conv_arbiter.
// Stimulus pushes the expected {lane, bcd, err} of every response in
// service order; a monitor pops and compares on each rsp_valid. A small
// converter model answers conv_init after a configurable latency using a
// hand-written operand -> BCD table.
module tb_bcd_conv_arbiter;

  localparam int N_REQ = 4;
  localparam int BIN_W = 8;
  localparam int BCD_W = 12;
  localparam int TO    = 64;

  typedef struct {
    int               lane;
    logic [BCD_W-1:0] bcd;
    logic             err;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   conv_lat;   // -1: converter never answers
  int   rsp_cyc;
  int   hold_left [N_REQ];
  exp_t sb [$];

  bcd_conv_arbiter_if #(.N_REQ(N_REQ), .BIN_W(BIN_W), .BCD_W(BCD_W)) bus ();

  bcd_conv_arbiter #(
    .N_REQ(N_REQ), .BIN_W(BIN_W), .BCD_W(BCD_W), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [BCD_W-1:0] bcd_of(input logic [BIN_W-1:0] b);
    case (b)
      8'd255:  return 12'h255;
      8'd7:    return 12'h007;
      8'd42:   return 12'h042;
      8'd128:  return 12'h128;
      8'd99:   return 12'h099;
      8'd100:  return 12'h100;
      8'd63:   return 12'h063;
      8'd37:   return 12'h037;
      8'd12:   return 12'h012;
      8'd250:  return 12'h250;
      8'd200:  return 12'h200;
      default: return 12'hEEE;
    endcase
  endfunction

  task automatic set_bin(input int lane, input logic [BIN_W-1:0] v);
    bus.bin_in[lane*BIN_W +: BIN_W] = v;
  endtask

  task automatic wait_launch(output int lc, output int waited);
    lc = 0;
    waited = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      waited++;
      if (bus.conv_init) begin
        lc = cyc;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL launch_wait: conv_init not seen, got none expected within 50 cycles");
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL idle_wait: %0d responses still pending after %0d cycles, expected 0", sb.size(), bound);
    sb.delete();
  endtask

  // converter model
  initial begin
    bus.conv_done = 1'b0;
    bus.conv_bcd  = '0;
    forever begin
      @(negedge clk);
      if (bus.conv_init && conv_lat >= 0) begin
        repeat (conv_lat) @(negedge clk);
        bus.conv_bcd  = bcd_of(bus.conv_bin);
        bus.conv_done = 1'b1;
        @(negedge clk);
        bus.conv_done = 1'b0;
      end
    end
  end

  // monitor / scoreboard, also drops req after the lane's last response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", bus.rsp_valid);
        end else begin
          e = sb.pop_front();
          chk("rsp_lane", 32'(bus.rsp_valid), 32'(1) << e.lane);
          chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
          chk("rsp_err", 32'(bus.err), 32'(e.err));
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (bus.rsp_valid[i] && hold_left[i] > 0) begin
            hold_left[i]--;
            if (hold_left[i] == 0) bus.req[i] = 1'b0;
          end
        end
      end else if (bus.err) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_err: got err=1 expected 0 outside a response");
      end
    end
  end

  initial begin
    int lc, waited;
    n_cmp = 0;
    n_bad = 0;
    conv_lat = -1;
    rsp_cyc = 0;
    for (int i = 0; i < N_REQ; i++) hold_left[i] = 0;
    rst = 1'b0;
    bus.req = '0;
    bus.bin_in = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_bcd_out", 32'(bus.bcd_out), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_conv_init", 32'(bus.conv_init), 0);
    chk("rst_conv_bin", 32'(bus.conv_bin), 0);
    @(posedge clk); #1 rst = 1'b1;

    // single request, lane 2, 255 -> 255, converter latency 20
    @(posedge clk); #1;
    set_bin(2, 8'd255);
    hold_left[2] = 1;
    conv_lat = 20;
    sb.push_back('{2, 12'h255, 1'b0});
    bus.req = 4'b0100;
    wait_launch(lc, waited);
    chk("req_latency", 32'(waited), 2);
    chk("single_gnt", 32'(bus.gnt), 32'b0100);
    chk("single_conv_bin", 32'(bus.conv_bin), 255);
    chk("single_busy", 32'(bus.busy), 1);
    @(negedge clk);
    chk("init_one_cycle", 32'(bus.conv_init), 0);
    chk("gnt_held", 32'(bus.gnt), 32'b0100);
    wait_idle(100);
    chk("rsp_latency", 32'(rsp_cyc - lc), 21);

    // all lanes after reset: served 0,1,2,3
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    set_bin(0, 8'd7);
    set_bin(1, 8'd42);
    set_bin(2, 8'd128);
    set_bin(3, 8'd99);
    conv_lat = 3;
    for (int i = 0; i < N_REQ; i++) hold_left[i] = 1;
    sb.push_back('{0, 12'h007, 1'b0});
    sb.push_back('{1, 12'h042, 1'b0});
    sb.push_back('{2, 12'h128, 1'b0});
    sb.push_back('{3, 12'h099, 1'b0});
    bus.req = 4'b1111;
    wait_idle(200);

    // fairness: lanes 0 and 1 hold for three responses each
    @(posedge clk); #1;
    set_bin(0, 8'd100);
    set_bin(1, 8'd63);
    conv_lat = 2;
    hold_left[0] = 3;
    hold_left[1] = 3;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{0, 12'h100, 1'b0});
      sb.push_back('{1, 12'h063, 1'b0});
    end
    bus.req = 4'b0011;
    wait_idle(300);

    // timeout: converter never answers
    @(posedge clk); #1;
    set_bin(3, 8'd250);
    conv_lat = -1;
    hold_left[3] = 1;
    sb.push_back('{3, 12'h000, 1'b1});
    bus.req = 4'b1000;
    wait_launch(lc, waited);
    wait_idle(200);
    chk("timeout_latency", 32'(rsp_cyc - lc), TO + 1);

    // next request after timeout proceeds normally
    @(posedge clk); #1;
    set_bin(1, 8'd37);
    conv_lat = 5;
    hold_left[1] = 1;
    sb.push_back('{1, 12'h037, 1'b0});
    bus.req = 4'b0010;
    wait_idle(100);

    // done on the same cycle the timer would expire: done wins
    @(posedge clk); #1;
    set_bin(2, 8'd128);
    conv_lat = TO;
    hold_left[2] = 1;
    sb.push_back('{2, 12'h128, 1'b0});
    bus.req = 4'b0100;
    wait_launch(lc, waited);
    wait_idle(200);
    chk("done_vs_timeout_latency", 32'(rsp_cyc - lc), TO + 1);

    // reset mid-WAIT, then a late done
    @(posedge clk); #1;
    set_bin(2, 8'd200);
    conv_lat = -1;
    hold_left[2] = 1;
    bus.req = 4'b0100;
    wait_launch(lc, waited);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    bus.req = '0;
    hold_left[2] = 0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'(bus.gnt), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_conv_bin", 32'(bus.conv_bin), 0);
    chk("midrst_bcd_out", 32'(bus.bcd_out), 0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;
    bus.conv_bcd = 12'h999;
    bus.conv_done = 1'b1;
    @(posedge clk); #1 bus.conv_done = 1'b0;
    @(negedge clk);
    chk("late_done_ignored", 32'(bus.busy), 0);
    set_bin(0, 8'd12);
    set_bin(3, 8'd250);
    conv_lat = 4;
    hold_left[0] = 1;
    hold_left[3] = 1;
    sb.push_back('{0, 12'h012, 1'b0});
    sb.push_back('{3, 12'h250, 1'b0});
    bus.req = 4'b1001;
    wait_idle(200);

    // operand isolation: lane 1 changes 42 -> 99 after the grant
    @(posedge clk); #1;
    set_bin(1, 8'd42);
    conv_lat = 6;
    hold_left[1] = 1;
    sb.push_back('{1, 12'h042, 1'b0});
    bus.req = 4'b0010;
    wait_launch(lc, waited);
    set_bin(1, 8'd99);
    @(negedge clk);
    chk("iso_conv_bin", 32'(bus.conv_bin), 42);
    wait_idle(100);
    chk("iso_conv_bin_after", 32'(bus.conv_bin), 42);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
